cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//   Shares a single physical-memory port between the instruction cache and the data cache.
//   Each cache issues 256-bit line reads/writes exactly as it would to pmem directly.
//   Sits between both cache instances and the cacheline adaptor at the top level.
//   Grants one requester at a time: round-robin on contention, owner held until pmem_resp.
// PARAMETERS
//   s_line   256  line width in bits (pmem data width)
//   s_addr   32   address width in bits
// PORTS
//   clk            in   1       clock; all state updates on rising edge
//   rst            in   1       reset, asynchronous assert, active-low
//   i_addr         in   s_addr  I-cache line address
//   i_read         in   1       I-cache line-read request
//   i_write        in   1       I-cache line-write request
//   i_wdata        in   s_line  I-cache write line
//   i_rdata        out  s_line  line returned to I-cache
//   i_resp         out  1       I-cache completion strobe
//   d_addr         in   s_addr  D-cache line address
//   d_read         in   1       D-cache line-read request
//   d_write        in   1       D-cache line-write (writeback) request
//   d_wdata        in   s_line  D-cache write line
//   d_rdata        out  s_line  line returned to D-cache
//   d_resp         out  1       D-cache completion strobe
//   pmem_address   out  s_addr  memory address
//   pmem_read      out  1       memory read strobe
//   pmem_write     out  1       memory write strobe
//   pmem_wdata     out  s_line  memory write line
//   pmem_rdata     in   s_line  memory read line
//   pmem_resp      in   1       memory completion
// BEHAVIOUR
//   - States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE, ARB_RECOVER. Reset -> ARB_IDLE, last_grant=ICACHE.
//   - Reset values: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=d_resp=0.
//   - Reset mid-transaction: abandon it immediately; no resp is issued.
//   - A requester is pending when its read|write is high. read&write together is illegal;
//     flagged by assertion. If it occurs, write takes precedence.
//   - IDLE, single pending: next state grants it.
//   - IDLE, both pending: grant the requester that is not last_grant (round-robin).
//   - IDLE, none pending: stay.
//   - Grant edge latches the owner's addr, wdata and op into registers.
//   - pmem_* are driven only from the latched registers, so they are stable for the whole transaction.
//   - pmem_read/pmem_write assert in the first cycle of ARB_ICACHE/ARB_DCACHE.
//     Latency: request in cycle N -> pmem strobe in cycle N+1.
//   - Strobe stays high until pmem_resp.
//   - In the cycle pmem_resp=1:
//       owner's resp=1 (combinational from pmem_resp & state); other resp=0;
//       next state ARB_RECOVER; last_grant <= owner.
//   - i_rdata and d_rdata = pmem_rdata unconditionally. Only the matching resp qualifies the data.
//   - ARB_RECOVER: exactly 1 cycle with all pmem strobes low. Owner must deassert its request here.
//     Prevents re-granting a stale request. Next state: ARB_IDLE.
//   - Requests arriving while the other side is owner are held off (resp=0). No queue depth:
//     each requester keeps its request asserted until its resp.
//   - Requester inputs changing mid-grant have no effect (latched copy used).
//   - pmem_resp outside ARB_ICACHE/ARB_DCACHE is ignored; assertion fires.
//   - Worst-case wait for a requester is one full transaction of the other plus 2 cycles.
//     No starvation.
// STRUCTURE
//   - Shared package arbiter_types:
//       enum arb_state_t {ARB_IDLE, ARB_ICACHE, ARB_DCACHE, ARB_RECOVER};
//       enum arb_owner_t {OWN_I, OWN_D};
//   - One sub-module, arb_rr_select (combinational): inputs i_pend, d_pend, last_grant;
//     outputs grant_valid, grant_owner.
//   - FSM, latch registers and resp routing stay in cache_arbiter.
// TESTING
//   1. Reset: rst=0 for 3 cycles with random inputs.
//      -> all pmem strobes 0, resps 0; first grant after release goes to D if both pending.
//   2. I-only read, addr 0x0000_0060, memory latency 5.
//      -> pmem_read high cycles 1-5, pmem_address=0x60, i_resp 1 cycle, 1 idle cycle after.
//   3. I read 0x100 and D write 0x200 both raised in cycle 0.
//      -> D served first (last_grant=I after reset), then I; D wdata seen on pmem_wdata.
//   4. D changes d_addr from 0x200 to 0x300 while owner.
//      -> pmem_address stays 0x200 until d_resp.
//   5. Back-to-back: D holds a new request after each resp while I pending.
//      -> grants strictly alternate D,I,D,I over 8 transactions.
//   6. Reset asserted mid-transaction (cycle 3 of a 6-cycle read).
//      -> strobes drop asynchronously; no resp; state IDLE after release.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// ============================================================================
//  Module      : arbiter_types (package)
//  Description : Shared state/owner encodings and default widths for the
//                I-cache / D-cache physical-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_types;

  localparam int C_S_LINE = 256;  // line width in bits
  localparam int C_S_ADDR = 32;   // address width in bits

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ICACHE  = 2'd1,
    ARB_DCACHE  = 2'd2,
    ARB_RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_rr_select.sv
// ============================================================================
//  Module      : arb_rr_select
//  Description : Combinational round-robin choice between the two caches.
//                When both are pending the side that did not win last wins.
//  Ports       : i_ipend, i_dpend   - request pending from I / D cache
//                i_last_grant       - owner of the most recent transaction
//                o_grant_valid      - at least one requester pending
//                o_grant_owner      - chosen owner (valid with o_grant_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr_select
  import arbiter_types::*;
(
  input  logic       i_ipend,
  input  logic       i_dpend,
  input  arb_owner_t i_last_grant,
  output logic       o_grant_valid,
  output arb_owner_t o_grant_owner
);

  always_comb begin
    o_grant_valid = i_ipend | i_dpend;
    o_grant_owner = OWN_I;
    if (i_ipend && i_dpend) begin
      o_grant_owner = (i_last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (i_dpend) begin
      o_grant_owner = OWN_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
//  Module      : cache_arbiter
//  Description : Shares one physical-memory port between the I-cache and the
//                D-cache. One owner at a time, round-robin on contention,
//                owner held until pmem_resp, then one recovery cycle.
//  Ports       : clk, rst (async, active-low)
//                i_addr/i_read/i_write/i_wdata -> i_rdata/i_resp   (I-cache)
//                d_addr/d_read/d_write/d_wdata -> d_rdata/d_resp   (D-cache)
//                pmem_address/read/write/wdata, pmem_rdata/resp    (memory)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
  import arbiter_types::*;
#(
  parameter int S_LINE = C_S_LINE,
  parameter int S_ADDR = C_S_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [S_ADDR-1:0] i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [S_LINE-1:0] i_wdata,
  output logic [S_LINE-1:0] i_rdata,
  output logic              i_resp,
  input  logic [S_ADDR-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [S_LINE-1:0] d_wdata,
  output logic [S_LINE-1:0] d_rdata,
  output logic              d_resp,
  output logic [S_ADDR-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  arb_owner_t        r_last;
  logic [S_ADDR-1:0] r_addr;
  logic [S_LINE-1:0] r_wdata;
  logic              r_op_write;

  logic              w_ipend;
  logic              w_dpend;
  logic              w_grant_valid;
  arb_owner_t        w_grant_owner;
  logic              w_busy;

  assign w_ipend = i_read | i_write;
  assign w_dpend = d_read | d_write;

  arb_rr_select u_rr_select (
    .i_ipend       (w_ipend),
    .i_dpend       (w_dpend),
    .i_last_grant  (r_last),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_valid) begin
          w_next = (w_grant_owner == OWN_D) ? ARB_DCACHE : ARB_ICACHE;
        end
      end
      ARB_ICACHE, ARB_DCACHE: begin
        if (pmem_resp) begin
          w_next = ARB_RECOVER;
        end
      end
      ARB_RECOVER: w_next = ARB_IDLE;
      default:     w_next = ARB_IDLE;
    endcase
  end

  // The request is latched on the grant edge so the memory side never sees
  // requester inputs wobble mid-transaction. Write wins over read if both set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_last     <= OWN_I;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB_IDLE && w_grant_valid) begin
        if (w_grant_owner == OWN_D) begin
          r_addr     <= d_addr;
          r_wdata    <= d_wdata;
          r_op_write <= d_write;
        end else begin
          r_addr     <= i_addr;
          r_wdata    <= i_wdata;
          r_op_write <= i_write;
        end
      end
      if (w_busy && pmem_resp) begin
        r_last <= (r_state == ARB_DCACHE) ? OWN_D : OWN_I;
      end
    end
  end

  // Strobes are decoded from state so they drop the instant reset asserts.
  assign w_busy       = (r_state == ARB_ICACHE) || (r_state == ARB_DCACHE);
  assign pmem_read    = w_busy & ~r_op_write;
  assign pmem_write   = w_busy &  r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  assign i_resp  = pmem_resp && (r_state == ARB_ICACHE);
  assign d_resp  = pmem_resp && (r_state == ARB_DCACHE);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

`ifndef SYNTHESIS
  a_i_rw_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(i_read && i_write));
  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write));
  a_resp_when_busy : assert property (@(posedge clk) disable iff (!rst)
    pmem_resp |-> w_busy);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Directed self-checking bench for cache_arbiter with a simple
//                fixed-latency memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_addr, d_addr, pmem_address;
  logic         i_read, i_write, d_read, d_write;
  logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
  logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 2;
  int mem_cnt;

  cache_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_addr       (i_addr),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_addr       (d_addr),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: resp on the mem_lat-th cycle of a strobe; read data tagged by address.
  always @(posedge clk or negedge rst) begin
    if (!rst) mem_cnt <= 0;
    else if (pmem_resp || !(pmem_read || pmem_write)) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end
  assign pmem_resp  = (pmem_read || pmem_write) && (mem_cnt == mem_lat - 1);
  assign pmem_rdata = {8{pmem_address ^ 32'hA5A5_0000}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serves any outstanding requests to completion, dropping each on its resp.
  task automatic drain();
    bit bi, bd, done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      bi = i_resp;
      bd = d_resp;
      step();
      if (bi) begin i_read = 1'b0; i_write = 1'b0; end
      if (bd) begin d_read = 1'b0; d_write = 1'b0; end
      if (!(i_read || i_write || d_read || d_write) && !pmem_read && !pmem_write) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout: requests still pending after 100 cycles, required completion");
    end
    step();
  endtask

  task automatic test_reset();
    int sel;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sel = $urandom_range(0, 2);
      i_read = (sel == 1); i_write = (sel == 2);
      sel = $urandom_range(0, 2);
      d_read = (sel == 1); d_write = (sel == 2);
      i_addr = $urandom; d_addr = $urandom;
      i_wdata = {8{$urandom}}; d_wdata = {8{$urandom}};
      @(negedge clk);
      checks++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_strobes: got %b required 0000", {pmem_read, pmem_write, i_resp, d_resp});
      end
      checks++;
      if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
        failures++;
        $display("FAIL reset_regs: addr=%h wdata[31:0]=%h required 0", pmem_address, pmem_wdata[31:0]);
      end
      step();
    end
    // Release with both pending: last_grant resets to I so D must win.
    i_read = 1'b1; i_write = 1'b0; i_addr = 32'h40;
    d_read = 1'b1; d_write = 1'b0; d_addr = 32'h80;
    rst = 1'b1;
    mem_lat = 2;
    step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h80) begin
      failures++;
      $display("FAIL reset_first_grant: read=%b addr=%h required read=1 addr=00000080", pmem_read, pmem_address);
    end
    drain();
  endtask

  task automatic test_i_read();
    logic [3:0] exp;
    mem_lat = 5;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin i_addr = 32'h60; i_read = 1'b1; end
      if (c == 6) i_read = 1'b0;
      @(negedge clk);
      exp = {(c >= 1 && c <= 5), 1'b0, (c == 5), 1'b0};
      checks++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== exp) begin
        failures++;
        $display("FAIL i_read_c%0d: rd/wr/iresp/dresp=%b required %b", c,
                 {pmem_read, pmem_write, i_resp, d_resp}, exp);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (pmem_address !== 32'h60) begin
          failures++;
          $display("FAIL i_read_addr_c%0d: got %h required 00000060", c, pmem_address);
        end
      end
      if (c == 5) begin
        checks++;
        if (i_rdata !== {8{32'hA5A5_0060}}) begin
          failures++;
          $display("FAIL i_read_rdata: got %h required %h", i_rdata[31:0], 32'hA5A5_0060);
        end
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    mem_lat = 3;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        i_addr = 32'h100; i_read = 1'b1;
        d_addr = 32'h200; d_write = 1'b1; d_wdata = {8{32'hDEAD_BEEF}};
      end
      if (c == 4) d_write = 1'b0;
      if (c == 9) i_read = 1'b0;
      @(negedge clk);
      exp = {(c >= 6 && c <= 8), (c >= 1 && c <= 3), (c == 8), (c == 3)};
      checks++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== exp) begin
        failures++;
        $display("FAIL contention_c%0d: rd/wr/iresp/dresp=%b required %b", c,
                 {pmem_read, pmem_write, i_resp, d_resp}, exp);
      end
      if (c == 2) begin
        checks++;
        if (pmem_address !== 32'h200 || pmem_wdata !== {8{32'hDEAD_BEEF}}) begin
          failures++;
          $display("FAIL contention_dwrite: addr=%h wdata=%h required 00000200/deadbeef",
                   pmem_address, pmem_wdata[31:0]);
        end
      end
      if (c == 7) begin
        checks++;
        if (pmem_address !== 32'h100) begin
          failures++;
          $display("FAIL contention_iaddr: got %h required 00000100", pmem_address);
        end
      end
      step();
    end
  endtask

  task automatic test_addr_stable();
    mem_lat = 4;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin d_addr = 32'h200; d_write = 1'b1; d_wdata = {8{32'h1111_2222}}; end
      if (c == 2) begin d_addr = 32'h300; d_wdata = {8{32'h3333_4444}}; end
      if (c == 5) d_write = 1'b0;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++;
        if (pmem_write !== 1'b1 || pmem_address !== 32'h200 || pmem_wdata !== {8{32'h1111_2222}}) begin
          failures++;
          $display("FAIL addr_stable_c%0d: wr=%b addr=%h wdata=%h required 1/00000200/11112222",
                   c, pmem_write, pmem_address, pmem_wdata[31:0]);
        end
      end
      checks++;
      if (d_resp !== (c == 4)) begin
        failures++;
        $display("FAIL addr_stable_dresp_c%0d: got %b required %b", c, d_resp, (c == 4));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 6;
    i_addr = 32'h180; i_read = 1'b1;
    step(); step(); step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: read=%b required 1", pmem_read);
    end
    #1 rst = 1'b0;
    i_read = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_async: got %b required 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid_hold_c%0d: got %b required 0000", c, {pmem_read, pmem_write, i_resp, d_resp});
      end
    end
    step();
    rst = 1'b1;
    mem_lat = 2;
    i_addr = 32'h240; i_read = 1'b1;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release: read=%b iresp=%b required 0/0", pmem_read, i_resp);
    end
    step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h240) begin
      failures++;
      $display("FAIL reset_mid_idle_grant: read=%b addr=%h required 1/00000240", pmem_read, pmem_address);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bit gi, gd, i_again, d_again;
    logic exp_d;
    mem_lat = 2;
    i_again = 1'b0; d_again = 1'b0;
    i_addr = 32'h400; i_read = 1'b1;
    d_addr = 32'h500; d_read = 1'b1;
    for (int k = 0; k < 200 && n < 8; k++) begin
      @(negedge clk);
      gi = i_resp; gd = d_resp;
      if (gi && gd) begin
        checks++; failures++;
        $display("FAIL b2b_both_resp: i_resp=1 d_resp=1 required one-hot");
      end else if (gi || gd) begin
        exp_d = (n % 2 == 0);
        checks++;
        if (gd !== exp_d || pmem_address !== (exp_d ? 32'h500 : 32'h400)) begin
          failures++;
          $display("FAIL b2b_order_%0d: d_owner=%b addr=%h required d_owner=%b addr=%h",
                   n, gd, pmem_address, exp_d, (exp_d ? 32'h500 : 32'h400));
        end
        n++;
      end
      step();
      if (gi) begin i_read = 1'b0; i_again = (n < 8); end
      else if (i_again) begin i_read = 1'b1; i_again = 1'b0; end
      if (gd) begin d_read = 1'b0; d_again = (n < 8); end
      else if (d_again) begin d_read = 1'b1; d_again = 1'b0; end
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d transactions required 8", n);
    end
    drain();
  endtask

  initial begin
    rst = 1'b0;
    i_addr = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    step();
    test_reset();
    test_i_read();
    test_contention();
    test_addr_stable();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
